sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one synchronous single-port SRAM between the fetch requester (inst, read-only) and the
//  memory-access requester (data, read/write). Uses a req/addr_ok/data_ok handshake with a response
//  hold stage. Sits between the pipeline stages and a unified SRAM in mycpu_top. Data has priority;
//  a starvation counter guarantees fetch progress.
// PARAMETERS
//  STARVE_MAX  4  max consecutive data grants while inst waits; 0 = inst always wins ties
// PORTS
//  clk           in   1   clock, all state on rising edge
//  resetn        in   1   asynchronous active-low reset
//  inst_req      in   1   fetch request, held with inst_addr until inst_addr_ok
//  inst_addr     in   32  fetch byte address
//  inst_addr_ok  out  1   fetch request accepted this cycle
//  inst_data_ok  out  1   fetch response valid, held until inst_rready
//  inst_rdata    out  32  fetch response data
//  inst_rready   in   1   fetch requester consumes response
//  data_req      in   1   data request, held with addr/we/wdata until data_addr_ok
//  data_we       in   4   byte write enables, 0 = read
//  data_addr     in   32  data byte address
//  data_wdata    in   32  store data
//  data_addr_ok  out  1   data request accepted this cycle
//  data_data_ok  out  1   data response (read data or write ack), held until data_rready
//  data_rdata    out  32  read data; 0 for write responses
//  data_rready   in   1   data requester consumes response
//  sram_en       out  1   SRAM enable
//  sram_we       out  4   SRAM byte write enables
//  sram_addr     out  32  SRAM address
//  sram_wdata    out  32  SRAM write data
//  sram_rdata    in   32  SRAM read data, valid the cycle after sram_en
// BEHAVIOUR
//  - State: IDLE (nothing in flight), RESP (SRAM output valid this cycle), HOLD (response in buf).
//    Registered: state, owner (inst/data), is_wr, buf[31:0], starve_cnt.
//  - Reset (async, resetn=0): state=IDLE, starve_cnt=0, buf=0.
//    All outputs 0 immediately. In-flight response is dropped.
//  - can_issue = IDLE | (RESP & owner's rready).
//  - Grant is combinational when can_issue:
//    data wins if data_req & !(inst_req & starve_cnt==STARVE_MAX); else inst wins if inst_req.
//  - A grant asserts the winner's addr_ok and sram_en in the same cycle.
//    sram_addr/we/wdata come from the winner; sram_we=0 for inst.
//    With no grant, sram_en/we/addr/wdata are 0. At most one addr_ok per cycle.
//  - Next state:
//    grant -> RESP (owner/is_wr latched).
//    RESP & rready & !grant -> IDLE.
//    RESP & !rready -> HOLD, buf <= is_wr ? 0 : sram_rdata.
//    HOLD & rready -> IDLE. No grants in HOLD; grants resume the cycle after exit.
//  - data_ok to owner in RESP and HOLD. rdata = HOLD ? buf : (is_wr ? 0 : sram_rdata).
//    Non-owner data_ok=0, rdata=0. Transfer completes on data_ok & rready.
//  - Latency: addr_ok in the request cycle; data_ok at minimum one cycle later.
//    Throughput is 1 req/cycle while rready stays high, including owner switches.
//  - starve_cnt: +1 (saturate at STARVE_MAX) when can_issue & inst_req & data granted.
//    Cleared on inst grant or when inst_req=0. Unchanged when !can_issue.
//  - Dropping req before addr_ok is legal and has no effect. Input changes after addr_ok are ignored.
// TESTING
//  - inst only, inst_req=1 addr 0x1c000000 then +4, rready=1 ->
//    addr_ok every cycle; data_ok next cycle with model word; 1 word/cycle.
//  - both req held, STARVE_MAX=4, rready=1 -> grant sequence D,D,D,D,I repeating; each data_ok to correct owner.
//  - data write we=4'hf addr 0x100 wdata 0xdeadbeef -> same-cycle sram_we=f/addr=0x100;
//    next cycle data_data_ok=1, data_rdata=0; later read of 0x100 returns 0xdeadbeef.
//  - data read, data_rready=0 for 3 cycles -> HOLD; data_data_ok and rdata stable; sram_en=0, inst_addr_ok=0;
//    rready=1 -> IDLE, grants resume next cycle.
//  - resetn=0 during RESP -> all outputs 0 asynchronously; after release no stale data_ok; starve_cnt=0.
//  - STARVE_MAX=0 with both req -> inst granted every cycle; data granted only when inst_req=0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: fetch, data and SRAM signals
// shared by the arbiter and its environment.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_rready;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        data_rready;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output inst_req, inst_addr, inst_rready,
    output data_req, data_we, data_addr,
    output data_wdata, data_rready, sram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  inst_req, inst_addr, inst_rready,
    input  data_req, data_we, data_addr,
    input  data_wdata, data_rready, sram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sync SRAM between fetch
// and data requesters; data first, starvation-bounded.
module sram_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           resetn,
  sram_port_arbiter_if.slave bus
);

  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [CW-1:0] starve_q, starve_d;

  logic rready;
  logic can_issue;
  logic starved;
  logic gnt_d;
  logic gnt_i;
  logic rsp_vld;
  logic [31:0] rsp_data;

  // owner_q: 1 = data, 0 = inst
  assign rready = owner_q ? bus.data_rready
                          : bus.inst_rready;

  // resetn gates grants so outputs drop at once
  assign can_issue = resetn &
    ((state_q == IDLE) |
     ((state_q == RESP) & rready));

  assign starved = bus.inst_req & (starve_q == SMAX);
  assign gnt_d = can_issue & bus.data_req & ~starved;
  assign gnt_i = can_issue & bus.inst_req & ~gnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      is_wr_q  <= 1'b0;
      rbuf_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      is_wr_q  <= is_wr_d;
      rbuf_q   <= rbuf_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    is_wr_d  = is_wr_q;
    rbuf_d   = rbuf_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      RESP: begin
        if (rready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          rbuf_d  = is_wr_q ? '0 : bus.sram_rdata;
        end
      end
      HOLD: if (rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (gnt_d | gnt_i) begin
      state_d = RESP;
      owner_d = gnt_d;
      is_wr_d = gnt_d & (|bus.data_we);
    end
    if (can_issue) begin
      if (!bus.inst_req || gnt_i)
        starve_d = '0;
      else if (gnt_d && starve_q != SMAX)
        starve_d = starve_q + CW'(1);
    end
  end

  assign rsp_vld  = (state_q == RESP) |
                    (state_q == HOLD);
  assign rsp_data = (state_q == HOLD) ? rbuf_q :
                    (is_wr_q ? '0 : bus.sram_rdata);

  always_comb begin
    bus.inst_addr_ok = gnt_i;
    bus.data_addr_ok = gnt_d;
    bus.inst_data_ok = rsp_vld & ~owner_q;
    bus.data_data_ok = rsp_vld & owner_q;
    bus.inst_rdata   = '0;
    bus.data_rdata   = '0;
    if (rsp_vld & ~owner_q) bus.inst_rdata = rsp_data;
    if (rsp_vld & owner_q)  bus.data_rdata = rsp_data;
    bus.sram_en    = gnt_d | gnt_i;
    bus.sram_we    = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    unique case (1'b1)
      gnt_d: begin
        bus.sram_we    = bus.data_we;
        bus.sram_addr  = bus.data_addr;
        bus.sram_wdata = bus.data_wdata;
      end
      gnt_i: bus.sram_addr = bus.inst_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed tests for the
// fetch/data SRAM arbiter with a small SRAM model.
module tb_sram_port_arbiter;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  sram_port_arbiter_if b0();
  sram_port_arbiter_if b1();

  sram_port_arbiter #(.STARVE_MAX(4)) u0 (
    .clk(clk), .resetn(resetn), .bus(b0)
  );
  sram_port_arbiter #(.STARVE_MAX(0)) u1 (
    .clk(clk), .resetn(resetn), .bus(b1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [31:0] a);
    return 32'ha5000000 | {24'h0, a[9:2]};
  endfunction

  // SRAM model: unwritten words read as model(addr);
  // output is garbage in cycles after no enable.
  logic [31:0] mem0 [256];
  logic [255:0] wv0;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [31:0] cur0;

  always @(posedge clk) begin
    if (!resetn) wv0 <= '0;
    if (b0.sram_en) begin
      cur0 = wv0[b0.sram_addr[9:2]] ?
             mem0[b0.sram_addr[9:2]] : model(b0.sram_addr);
      rd0 <= cur0;
      if (b0.sram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (b0.sram_we[b])
            cur0[8*b +: 8] = b0.sram_wdata[8*b +: 8];
        mem0[b0.sram_addr[9:2]] <= cur0;
        wv0[b0.sram_addr[9:2]]  <= 1'b1;
      end
    end else begin
      rd0 <= 32'h0bad0bad;
    end
  end

  always @(posedge clk)
    rd1 <= b1.sram_en ? (b1.sram_addr ^ 32'h5a5a5a5a)
                      : 32'h0bad0bad;

  assign b0.sram_rdata = rd0;
  assign b1.sram_rdata = rd1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    b0.inst_req = 1'b1;
    b0.data_req = 1'b1;
    b1.inst_req = 1'b1;
    b1.data_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({b0.inst_addr_ok, b0.data_addr_ok,
         b0.inst_data_ok, b0.data_data_ok,
         b0.sram_en, b0.sram_we, b0.sram_addr,
         b0.sram_wdata, b0.inst_rdata,
         b0.data_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got aok=%b%b en=%b addr=%h exp 0",
        b0.inst_addr_ok, b0.data_addr_ok,
        b0.sram_en, b0.sram_addr);
    end
    n_tests++;
    if ({b1.inst_addr_ok, b1.data_addr_ok,
         b1.sram_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outs1 got %b%b%b exp 000",
        b1.inst_addr_ok, b1.data_addr_ok, b1.sram_en);
    end
    b0.inst_req = 1'b0;
    b0.data_req = 1'b0;
    b1.inst_req = 1'b0;
    b1.data_req = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_inst_stream;
    logic [31:0] a;
    b0.inst_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 32'h1c000000 + 32'(4 * k);
      b0.inst_addr = a;
      #1;
      n_tests++;
      if ({b0.inst_addr_ok, b0.sram_en, b0.sram_addr,
           b0.sram_we} !== {2'b11, a, 4'h0}) begin
        n_fail++;
        $display("FAIL inst_issue k=%0d got aok=%b en=%b addr=%h exp 1 1 %h",
          k, b0.inst_addr_ok, b0.sram_en, b0.sram_addr, a);
      end
      if (k > 0) begin
        n_tests++;
        if ({b0.inst_data_ok, b0.inst_rdata} !==
            {1'b1, model(a - 32'd4)}) begin
          n_fail++;
          $display("FAIL inst_resp k=%0d got ok=%b %h exp 1 %h",
            k, b0.inst_data_ok, b0.inst_rdata, model(a - 32'd4));
        end
      end
      tick();
    end
    b0.inst_req = 1'b0;
    #1;
    n_tests++;
    if ({b0.inst_data_ok, b0.inst_rdata, b0.sram_en} !==
        {1'b1, 32'ha5000003, 1'b0}) begin
      n_fail++;
      $display("FAIL inst_last got ok=%b %h en=%b exp 1 a5000003 0",
        b0.inst_data_ok, b0.inst_rdata, b0.sram_en);
    end
    tick();
    n_tests++;
    if (b0.inst_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL inst_idle got %b exp 0", b0.inst_data_ok);
    end
  endtask

  task automatic test_write;
    b0.data_req   = 1'b1;
    b0.data_we    = 4'hf;
    b0.data_addr  = 32'h100;
    b0.data_wdata = 32'hdeadbeef;
    #1;
    n_tests++;
    if ({b0.data_addr_ok, b0.sram_en, b0.sram_we,
         b0.sram_addr, b0.sram_wdata} !==
        {2'b11, 4'hf, 32'h100, 32'hdeadbeef}) begin
      n_fail++;
      $display("FAIL wr_issue got aok=%b we=%h addr=%h wd=%h exp 1 f 100 deadbeef",
        b0.data_addr_ok, b0.sram_we, b0.sram_addr, b0.sram_wdata);
    end
    tick();
    b0.data_we = 4'h0;
    #1;
    n_tests++;
    if ({b0.data_data_ok, b0.data_rdata, b0.data_addr_ok,
         b0.sram_we} !== {1'b1, 32'h0, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL wr_resp got ok=%b rd=%h aok=%b we=%h exp 1 0 1 0",
        b0.data_data_ok, b0.data_rdata, b0.data_addr_ok, b0.sram_we);
    end
    tick();
    b0.data_req = 1'b0;
    #1;
    n_tests++;
    if ({b0.data_data_ok, b0.data_rdata} !==
        {1'b1, 32'hdeadbeef}) begin
      n_fail++;
      $display("FAIL rd_after_wr got ok=%b %h exp 1 deadbeef",
        b0.data_data_ok, b0.data_rdata);
    end
    tick();
  endtask

  task automatic test_hold;
    b0.inst_addr   = 32'h1c000010;
    b0.data_req    = 1'b1;
    b0.data_we     = 4'h0;
    b0.data_addr   = 32'h104;
    b0.data_rready = 1'b0;
    #1;
    n_tests++;
    if (b0.data_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_issue got %b exp 1", b0.data_addr_ok);
    end
    tick();
    b0.data_req = 1'b0;
    b0.inst_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) b0.data_rready = 1'b1;
      #1;
      n_tests++;
      if ({b0.data_data_ok, b0.data_rdata, b0.sram_en,
           b0.inst_addr_ok} !== {1'b1, 32'ha5000041, 2'b00}) begin
        n_fail++;
        $display("FAIL hold_c%0d got ok=%b rd=%h en=%b iaok=%b exp 1 a5000041 0 0",
          k, b0.data_data_ok, b0.data_rdata, b0.sram_en, b0.inst_addr_ok);
      end
      tick();
    end
    #1;
    n_tests++;
    if ({b0.inst_addr_ok, b0.data_data_ok} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_resume got iaok=%b dok=%b exp 1 0",
        b0.inst_addr_ok, b0.data_data_ok);
    end
    tick();
    b0.inst_req = 1'b0;
    #1;
    n_tests++;
    if ({b0.inst_data_ok, b0.inst_rdata} !==
        {1'b1, 32'ha5000004}) begin
      n_fail++;
      $display("FAIL hold_inst_resp got %b %h exp 1 a5000004",
        b0.inst_data_ok, b0.inst_rdata);
    end
    tick();
  endtask

  // pat bit k = 1 means data is granted in cycle k
  task automatic test_starve(input int n,
                             input logic [15:0] pat,
                             input string nm);
    logic [31:0] exp_rd;
    b0.inst_addr = 32'h1c000020;
    b0.data_addr = 32'h200;
    b0.data_we   = 4'h0;
    b0.inst_req  = 1'b1;
    b0.data_req  = 1'b1;
    for (int k = 0; k <= n; k++) begin
      if (k == n) begin
        b0.inst_req = 1'b0;
        b0.data_req = 1'b0;
      end
      #1;
      if (k < n) begin
        n_tests++;
        if ({b0.data_addr_ok, b0.inst_addr_ok} !==
            {pat[k], ~pat[k]}) begin
          n_fail++;
          $display("FAIL %s_gnt k=%0d got d=%b i=%b exp d=%b",
            nm, k, b0.data_addr_ok, b0.inst_addr_ok, pat[k]);
        end
      end
      if (k > 0) begin
        exp_rd = pat[k-1] ? 32'ha5000080 : 32'ha5000008;
        n_tests++;
        if ({b0.data_data_ok, b0.inst_data_ok,
             pat[k-1] ? b0.data_rdata : b0.inst_rdata} !==
            {pat[k-1], ~pat[k-1], exp_rd}) begin
          n_fail++;
          $display("FAIL %s_resp k=%0d got dok=%b iok=%b exp dok=%b rd %h",
            nm, k, b0.data_data_ok, b0.inst_data_ok, pat[k-1], exp_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_resp;
    b0.data_addr = 32'h200;
    b0.data_we   = 4'h0;
    b0.inst_req  = 1'b1;
    b0.data_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (b0.data_addr_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_pre k=%0d got %b exp 1", k, b0.data_addr_ok);
      end
      tick();
    end
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({b0.inst_addr_ok, b0.data_addr_ok,
         b0.inst_data_ok, b0.data_data_ok,
         b0.sram_en, b0.sram_we, b0.sram_addr,
         b0.inst_rdata, b0.data_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_async got dok=%b aok=%b%b en=%b rd=%h exp 0",
        b0.data_data_ok, b0.inst_addr_ok, b0.data_addr_ok,
        b0.sram_en, b0.data_rdata);
    end
    b0.inst_req = 1'b0;
    b0.data_req = 1'b0;
    #1;
    resetn = 1'b1;
    tick();
    n_tests++;
    if ({b0.data_data_ok, b0.inst_data_ok} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_stale got %b%b exp 00",
        b0.data_data_ok, b0.inst_data_ok);
    end
    test_starve(5, 16'h000f, "rst_starve");
  endtask

  task automatic test_starve0;
    b1.inst_addr = 32'h1c000040;
    b1.data_addr = 32'h300;
    b1.data_we   = 4'h0;
    b1.inst_req  = 1'b1;
    b1.data_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({b1.inst_addr_ok, b1.data_addr_ok} !== 2'b10) begin
        n_fail++;
        $display("FAIL s0_gnt k=%0d got i=%b d=%b exp 1 0",
          k, b1.inst_addr_ok, b1.data_addr_ok);
      end
      if (k > 0) begin
        n_tests++;
        if ({b1.inst_data_ok, b1.inst_rdata} !==
            {1'b1, 32'h1c000040 ^ 32'h5a5a5a5a}) begin
          n_fail++;
          $display("FAIL s0_resp k=%0d got %b %h",
            k, b1.inst_data_ok, b1.inst_rdata);
        end
      end
      tick();
    end
    b1.inst_req = 1'b0;
    #1;
    n_tests++;
    if ({b1.data_addr_ok, b1.inst_addr_ok,
         b1.inst_data_ok} !== 3'b101) begin
      n_fail++;
      $display("FAIL s0_data got d=%b i=%b iok=%b exp 1 0 1",
        b1.data_addr_ok, b1.inst_addr_ok, b1.inst_data_ok);
    end
    tick();
    b1.data_req = 1'b0;
    #1;
    n_tests++;
    if ({b1.data_data_ok, b1.data_rdata} !==
        {1'b1, 32'h300 ^ 32'h5a5a5a5a}) begin
      n_fail++;
      $display("FAIL s0_dresp got %b %h exp 1 %h",
        b1.data_data_ok, b1.data_rdata, 32'h300 ^ 32'h5a5a5a5a);
    end
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    resetn  = 1'b0;
    b0.inst_req = 1'b0;  b1.inst_req = 1'b0;
    b0.inst_addr = '0;   b1.inst_addr = '0;
    b0.inst_rready = 1'b1; b1.inst_rready = 1'b1;
    b0.data_req = 1'b0;  b1.data_req = 1'b0;
    b0.data_we = '0;     b1.data_we = '0;
    b0.data_addr = '0;   b1.data_addr = '0;
    b0.data_wdata = '0;  b1.data_wdata = '0;
    b0.data_rready = 1'b1; b1.data_rready = 1'b1;
    test_reset();
    test_inst_stream();
    test_write();
    test_hold();
    test_starve(10, 16'h01ef, "starve");
    test_reset_resp();
    test_starve0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
